intc: RTL and testbench

Memory-mapped programmable interrupt controller and bus responder for the control unit's `rd`/`wr` data bus. It collects up to 32 external interrupt sources, latches them as pending, masks them with a software enable register, and drives the single `irq` line that the control unit samples in DECODE and execute states. Software reads a CLAIM register to get the highest-priority source ID. Interrupt-handling software reaches the controller through the `LD`/`ST` instructions of the interrupt service routine at vector 1.

---
 rtl/intc_pkg.sv | 15 +
 rtl/intc_sync.sv | 23 ++
 rtl/intc.sv | 117 +++++++++++
 tb/tb_intc.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// Shared definitions for the interrupt controller: register offsets and sizing constants.
package intc_pkg;

   localparam int INTC_MAX_SRC = 32;
   localparam int INTC_CLAIM_W = 6;

   typedef enum logic [2:0] {
      PENDING = 3'd0,
      ENABLE  = 3'd1,
      CLEAR   = 3'd2,
      CLAIM   = 3'd3,
      EDGE    = 3'd4
   } intc_reg_e;

endpackage

// File: rtl/intc_sync.sv
// Parameterized-width two-flop synchronizer for the raw interrupt source inputs.
module intc_sync #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/intc.sv
// Programmable interrupt controller with a memory-mapped register bus and priority claim.
// Define INTC_SYNC_EN to put a two-flop synchronizer in front of the sources.
module intc
   import intc_pkg::*;
#(
   parameter int NUM_SRC = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               rd,
   input  logic               wr,
   input  logic [2:0]         addr,
   input  logic [31:0]        data_in,
   output logic [31:0]        data_out,
   input  logic [NUM_SRC-1:0] src,
   output logic               irq
);

   logic [NUM_SRC-1:0]      s;
   logic [NUM_SRC-1:0]      s_q;
   logic [NUM_SRC-1:0]      pending;
   logic [NUM_SRC-1:0]      enable;
   logic [NUM_SRC-1:0]      edge_mode;
   logic [NUM_SRC-1:0]      set_vec;
   logic [NUM_SRC-1:0]      clr_vec;
   logic [NUM_SRC-1:0]      claim_hot;
   logic [NUM_SRC-1:0]      pending_nxt;
   logic [INTC_CLAIM_W-1:0] claim_val;
   logic [INTC_MAX_SRC-1:0] pending_w;
   logic [INTC_MAX_SRC-1:0] enable_w;
   logic [INTC_MAX_SRC-1:0] edge_w;
   logic                    rd_hit;
   logic                    wr_hit;
   logic                    claim_fire;
   logic                    unused_data;

   // Lowest index wins; result is index+1 so that 0 means "nothing requesting".
   function automatic logic [INTC_CLAIM_W-1:0] prio_enc(input logic [NUM_SRC-1:0] req);
      prio_enc = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req[i]) prio_enc = INTC_CLAIM_W'(i + 1);
      end
   endfunction

`ifdef INTC_SYNC_EN
   intc_sync #(.WIDTH(NUM_SRC)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (src),
      .q   (s)
   );
`else
   assign s = src;
`endif

   assign rd_hit      = en & rd;
   assign wr_hit      = en & wr;
   assign claim_val   = prio_enc(pending & enable);
   assign claim_fire  = rd_hit && (addr == CLAIM) && (claim_val != '0);
   assign irq         = |(pending & enable);
   assign unused_data = ^data_in;

   // Level sources set whenever high; edge sources only on a 0->1 step of s.
   // A set always beats a clear landing on the same edge.
   // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      claim_hot = '0;
      clr_vec   = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         claim_hot[i] = claim_fire && (claim_val == INTC_CLAIM_W'(i + 1));
      end
      if (wr_hit && (addr == CLEAR)) clr_vec = data_in[NUM_SRC-1:0];
      clr_vec     = clr_vec | claim_hot;
      set_vec     = s & (~edge_mode | ~s_q);
      pending_nxt = set_vec | (pending & ~clr_vec);
   end

   always_comb begin
      pending_w                = '0;
      enable_w                 = '0;
      edge_w                   = '0;
      pending_w[NUM_SRC-1:0]   = pending;
      enable_w[NUM_SRC-1:0]    = enable;
      edge_w[NUM_SRC-1:0]      = edge_mode;
   end

   // Zero-wait-state read mux; idle bus reads as 0.
   always_comb begin
      data_out = '0;
      if (rd_hit) begin
         case (addr)
            PENDING: data_out = pending_w;
            ENABLE:  data_out = enable_w;
            CLAIM:   data_out = 32'(claim_val);
            EDGE:    data_out = edge_w;
            default: data_out = '0;
         endcase
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s_q       <= '0;
         pending   <= '0;
         enable    <= '0;
         edge_mode <= '0;
      end else begin
         s_q     <= s;
         pending <= pending_nxt;
         if (wr_hit && (addr == ENABLE)) enable    <= data_in[NUM_SRC-1:0];
         if (wr_hit && (addr == EDGE))   edge_mode <= data_in[NUM_SRC-1:0];
      end
   end

endmodule

// File: tb/tb_intc.sv
// Directed self-checking bench for intc; expected values are hand-derived constants.
module tb_intc;
   import intc_pkg::*;

`ifdef INTC_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic        clk;
   logic        rst;
   logic        en;
   logic        rd;
   logic        wr;
   logic [2:0]  addr;
   logic [31:0] data_in;
   logic [31:0] data_out;
   logic [15:0] src;
   logic        irq;
   logic [15:0] src_v;

   int compared   = 0;
   int mismatched = 0;

   intc #(.NUM_SRC(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .rd       (rd),
      .wr       (wr),
      .addr     (addr),
      .data_in  (data_in),
      .data_out (data_out),
      .src      (src),
      .irq      (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One bus cycle: drive at the falling edge, settle, return for sampling.
   task automatic op(input logic e, input logic r, input logic w,
                     input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      en = e; rd = r; wr = w; addr = a; data_in = d; src = src_v;
      #1;
   endtask

   task automatic idle();
      op(1'b0, 1'b0, 1'b0, 3'd0, 32'h0);
   endtask

   task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
      op(1'b1, 1'b0, 1'b1, a, d);
   endtask

   task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
      op(1'b1, 1'b1, 1'b0, a, 32'h0);
      check(tag, data_out, exp);
   endtask

   task automatic irq_chk(input string tag, input logic exp);
      check(tag, {31'b0, irq}, {31'b0, exp});
   endtask

   initial begin
      rst = 1'b0; en = 1'b0; rd = 1'b0; wr = 1'b0;
      addr = '0; data_in = '0; src = '0; src_v = '0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      irq_chk("rst_irq", 1'b0);
      check("rst_dout", data_out, 32'h0);
      @(negedge clk);
      rst = 1'b1;
      rd_chk("rst_enable", ENABLE, 32'h0);
      rd_chk("rst_pending", PENDING, 32'h0);
      rd_chk("rst_edge", EDGE, 32'h0);

      // Level path on source 3
      wr_reg(ENABLE, 32'h0000_0008);
      src_v = 16'h0008;
      idle();
      irq_chk("lvl_irq_before", 1'b0);
      repeat (LAT) idle();
      idle();
      irq_chk("lvl_irq_set", 1'b1);
      rd_chk("lvl_pending", PENDING, 32'h0000_0008);
      rd_chk("lvl_claim", CLAIM, 32'd4);
      src_v = 16'h0000;
      idle();
      repeat (LAT) idle();
      rd_chk("lvl_claim2", CLAIM, 32'd4);
      idle();
      irq_chk("lvl_irq_drop", 1'b0);
      rd_chk("lvl_pending_clr", PENDING, 32'h0);

      // Priority and back-to-back claims
      wr_reg(EDGE, 32'h0000_FFFF);
      wr_reg(ENABLE, 32'h0000_FFFF);
      src_v = 16'h0024;
      idle();
      src_v = 16'h0000;
      idle();
      repeat (LAT) idle();
      rd_chk("pri_pending", PENDING, 32'h0000_0024);
      rd_chk("pri_claim_a", CLAIM, 32'd3);
      irq_chk("pri_irq_mid", 1'b1);
      rd_chk("pri_claim_b", CLAIM, 32'd6);
      rd_chk("pri_claim_c", CLAIM, 32'd0);
      irq_chk("pri_irq_low", 1'b0);
      idle();

      // Masking
      wr_reg(ENABLE, 32'h0);
      src_v = 16'h0080;
      idle();
      src_v = 16'h0000;
      idle();
      repeat (LAT) idle();
      rd_chk("mask_pending", PENDING, 32'h0000_0080);
      irq_chk("mask_irq_off", 1'b0);
      rd_chk("mask_claim", CLAIM, 32'd0);
      rd_chk("mask_pending_kept", PENDING, 32'h0000_0080);
      wr_reg(ENABLE, 32'h0000_0080);
      irq_chk("mask_irq_wcycle", 1'b0);
      idle();
      irq_chk("mask_irq_on", 1'b1);
      wr_reg(CLEAR, 32'h0000_0080);
      idle();
      rd_chk("clear_pending", PENDING, 32'h0);
      irq_chk("clear_irq", 1'b0);

      // Set beats clear on the same edge
      src_v = 16'h0002;
      repeat (LAT) idle();
      wr_reg(CLEAR, 32'h0000_0002);
      idle();
      rd_chk("soc_pending", PENDING, 32'h0000_0002);
      src_v = 16'h0000;
      wr_reg(CLEAR, 32'h0000_0002);
      repeat (LAT) idle();
      rd_chk("soc_cleared", PENDING, 32'h0);

      // Bus boundaries
      op(1'b0, 1'b1, 1'b1, ENABLE, 32'h0000_FFFF);
      check("nosel_dout", data_out, 32'h0);
      rd_chk("nosel_enable", ENABLE, 32'h0000_0080);
      rd_chk("addr6", 3'd6, 32'h0);
      rd_chk("clear_reads0", CLEAR, 32'h0);
      wr_reg(PENDING, 32'h0000_FFFF);
      rd_chk("pending_ro", PENDING, 32'h0);
      wr_reg(ENABLE, 32'hFFFF_FFFF);
      rd_chk("enable_width", ENABLE, 32'h0000_FFFF);
      rd_chk("edge_rb", EDGE, 32'h0000_FFFF);

      // Reset asserted in the middle of an ENABLE write
      wr_reg(ENABLE, 32'h0000_0001);
      src_v = 16'h0001;
      idle();
      src_v = 16'h0000;
      idle();
      repeat (LAT) idle();
      irq_chk("prerst_irq", 1'b1);
      @(negedge clk);
      en = 1'b1; wr = 1'b1; addr = ENABLE; data_in = 32'h0000_FFFF;
      #2;
      rst = 1'b0;
      #1;
      irq_chk("midrst_irq", 1'b0);
      @(negedge clk);
      en = 1'b0; wr = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      rd_chk("postrst_enable", ENABLE, 32'h0);
      rd_chk("postrst_pending", PENDING, 32'h0);
      rd_chk("postrst_edge", EDGE, 32'h0);
      rd_chk("postrst_claim", CLAIM, 32'h0);
      irq_chk("postrst_irq", 1'b0);
      idle();
      check("postrst_dout_idle", data_out, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
